// File: rtl/srl_trigger_loader.sv
// srl_trigger_loader: serially loads one SRLC16E match LUT per input nibble
// from a value/mask pair, shifting address 15 first so mem[a] = match(a).
//
// Ports:
//   clock, reset_n         clock, async active-low reset
//   cfg_valid/cfg_ready    load request handshake (ready = loader idle)
//   cfg_value/cfg_mask     compare value and care mask (1 = compared)
//   srl_ce, srl_d          SRL shift enable and per-chain serial data
//   busy, done             load in progress / one-cycle completion pulse
module srl_trigger_loader #(
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [WIDTH-1:0]       cfg_value,
  input  logic [WIDTH-1:0]       cfg_mask,
  output logic                   srl_ce,
  output logic [WIDTH/4-1:0]     srl_d,
  output logic                   busy,
  output logic                   done
);

  localparam int NUM_CHAINS = WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              count_q;
  logic [WIDTH-1:0]        value_q;
  logic [WIDTH-1:0]        mask_q;
  logic                    ready_q;
  logic                    ce_q;
  logic [NUM_CHAINS-1:0]   d_q;
  logic                    busy_q;
  logic                    done_q;

  // Match bit for LUT address a on every chain: masked nibble equality.
  function automatic logic [NUM_CHAINS-1:0] match_f(
    input logic [3:0]       a,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] m
  );
    logic [NUM_CHAINS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      r[i] = ((a ^ v[4*i +: 4]) & m[4*i +: 4]) == 4'b0;
    end
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      value_q <= '0;
      mask_q  <= '0;
      ready_q <= 1'b1;
      ce_q    <= 1'b0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_valid && ready_q) begin
            // Address 15 is presented on the accept edge from the raw
            // inputs, since the latched copy is not visible until next edge.
            value_q <= cfg_value;
            mask_q  <= cfg_mask;
            count_q <= 4'd15;
            ce_q    <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            d_q     <= match_f(4'd15, cfg_value, cfg_mask);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_q == 4'd0) begin
            // ce held through this edge, so the 16th shift lands here.
            ce_q    <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            count_q <= count_q - 4'd1;
            d_q     <= match_f(count_q - 4'd1, value_q, mask_q);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ce_q    <= 1'b0;
          d_q     <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign srl_ce    = ce_q;
  assign srl_d     = d_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_srl_trigger_loader.sv
// Bench for srl_trigger_loader: SRLC16E models on each chain, table of
// value/mask loads with expected LUT contents, plus reset/overlap sequences.
module tb_srl_trigger_loader;

  logic        clock;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_value;
  logic [31:0] cfg_mask;
  logic        srl_ce;
  logic [7:0]  srl_d;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  srl_trigger_loader #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_value (cfg_value),
    .cfg_mask  (cfg_mask),
    .srl_ce    (srl_ce),
    .srl_d     (srl_d),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRLC16E behavioural model: shift in at bit 0 on ce, Q = mem[A].
  logic [15:0] mem [8];
  always @(posedge clock) begin
    if (srl_ce) begin
      for (int i = 0; i < 8; i++) mem[i] <= {mem[i][14:0], srl_d[i]};
    end
  end

  typedef struct {
    logic [31:0]  v;
    logic [31:0]  m;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fref(input logic [3:0] a,
                                      input logic [31:0] v,
                                      input logic [31:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] vn, mn;
      vn = v[4*i +: 4];
      mn = m[4*i +: 4];
      r[i] = ((a & mn) == (vn & mn));
    end
    return r;
  endfunction

  function automatic logic [127:0] mem_all();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = mem[i];
    return r;
  endfunction

  task automatic do_load(input logic [31:0] v, input logic [31:0] m,
                         input bit intf);
    int k;
    int dbad;
    @(negedge clock);
    k = 0;
    while (!cfg_ready && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("ready_pre", 128'(cfg_ready), 128'(1));
    cfg_value = v;
    cfg_mask  = m;
    cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    cfg_value = $urandom;
    cfg_mask  = $urandom;
    chk("accept", 128'({busy, srl_ce, cfg_ready}), 128'(3'b110));
    k = 0;
    dbad = 0;
    while (srl_ce && k < 40) begin
      if (srl_d !== fref(4'(15 - k), v, m)) dbad++;
      if (!busy || cfg_ready || done) dbad++;
      if (intf && k == 4) begin
        cfg_valid = 1'b1;
        cfg_value = ~v;
        cfg_mask  = '1;
      end
      if (intf && k == 6) cfg_valid = 1'b0;
      k++;
      @(negedge clock);
    end
    chk("ce_len", 128'(k), 128'(16));
    chk("d_seq", 128'(dbad), 128'(0));
    chk("done_pulse", 128'({done, busy, srl_ce, srl_d, cfg_ready}),
        128'({1'b1, 1'b1, 1'b0, 8'h00, 1'b0}));
    @(negedge clock);
    chk("idle_back", 128'({done, busy, cfg_ready}), 128'(3'b001));
  endtask

  initial begin
    int dn;
    vecs[0] = '{32'h12345678, 32'h00000000, {8{16'hFFFF}}};
    vecs[1] = '{32'h0000000A, 32'h0000000F, {{7{16'hFFFF}}, 16'h0400}};
    vecs[2] = '{32'h00000005, 32'h00000007, {{7{16'hFFFF}}, 16'h2020}};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, {8{16'h8000}}};
    vecs[4] = '{32'h00000000, 32'hFFFFFFFF, {8{16'h0001}}};
    vecs[5] = '{32'h0F0F0F0F, 32'hF0F0F0F0, {4{16'h0001, 16'hFFFF}}};
    vecs[6] = '{32'h80000000, 32'h88888888, {16'hFF00, {7{16'h00FF}}}};

    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_value = '0;
    cfg_mask  = '0;

    // Reset holds outputs idle regardless of inputs.
    repeat (4) begin
      @(negedge clock);
      cfg_valid = 1'($urandom);
      cfg_value = $urandom;
      cfg_mask  = $urandom;
      #1;
      chk("rst_hold", 128'({cfg_ready, srl_ce, srl_d, busy, done}),
          128'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    end
    @(negedge clock);
    cfg_valid = 1'b0;
    reset_n   = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("rst_rel", 128'({cfg_ready, srl_ce, srl_d, busy, done}),
          128'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    end

    for (int t = 0; t < 7; t++) begin
      do_load(vecs[t].v, vecs[t].m, 1'b0);
      chk($sformatf("mem_v%0d", t), mem_all(), vecs[t].exp);
      if (t == 1) begin
        chk("readA", 128'(mem[0][4'hA]), 128'(1));
        chk("readB", 128'(mem[0][4'hB]), 128'(0));
      end
    end

    // Second request mid-shift is ignored.
    do_load(32'h0000000A, 32'h0000000F, 1'b1);
    chk("mem_overlap", mem_all(), vecs[1].exp);
    @(negedge clock);
    chk("no_requeue", 128'({busy, srl_ce}), 128'(2'b00));

    // Reset in the middle of a load.
    do_load(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(negedge clock);
    cfg_value = 32'h0000000A;
    cfg_mask  = 32'h0000000F;
    cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    repeat (8) @(negedge clock);
    chk("mid_busy", 128'({srl_ce, busy}), 128'(2'b11));
    reset_n = 1'b0;
    #1;
    chk("rst_mid", 128'({srl_ce, busy, done, cfg_ready, srl_d}),
        128'({1'b0, 1'b0, 1'b0, 1'b1, 8'h00}));
    @(negedge clock);
    reset_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clock);
      if (done || srl_ce) dn++;
    end
    chk("no_done", 128'(dn), 128'(0));
    do_load(32'h0000000A, 32'h0000000F, 1'b0);
    chk("mem_after_rst", mem_all(), vecs[1].exp);
    chk("readA2", 128'(mem[0][4'hA]), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
